// File: rtl/nios_system_cpu_jtag_mem_pkg.sv
// Shared types and constants for the JTAG debug memory sequencer.
// Holds the FSM encoding, the jdo field layout and the fixed byte-enable.
package nios_system_cpu_jtag_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mem_state_e;

  localparam int JDO_W    = 38;
  localparam int OP_BIT   = 35;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] BYTEENABLE = 4'hF;

endpackage

// File: rtl/nios_system_cpu_jtag_mem_timeout.sv
// Consecutive-waitrequest counter for one bus command.
// expired is high on the wait cycle that brings the count to TIMEOUT_CYCLES.
module nios_system_cpu_jtag_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable && !expired)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/nios_system_cpu_jtag_mem_sequencer.sv
// JTAG debug memory sequencer: turns ocimem strobes into single-word Avalon
// reads/writes with auto-increment, waitrequest timeout and overrun reporting.
module nios_system_cpu_jtag_mem_sequencer
  import nios_system_cpu_jtag_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  mem_state_e state;
  logic       overrun;
  logic       strobe_any;
  logic       expired;
  logic       unused_jdo;

  assign strobe_any     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign busy           = (state != ST_IDLE);
  assign avm_byteenable = BYTEENABLE;
  assign unused_jdo     = ^{jdo[JDO_W-1:ADDR_W], jdo[1:0]};

  // Held clear while idle, so every command starts counting from zero.
  nios_system_cpu_jtag_mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy),
    .enable (busy && avm_waitrequest),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            avm_address <= {jdo[ADDR_W-1:2], 2'b00};
            overrun     <= 1'b0;
            if (jdo[OP_BIT]) begin
              state         <= ST_READ;
              avm_read      <= 1'b1;
              monitor_ready <= 1'b0;
              monitor_error <= 1'b0;
            end
          end else if (take_action_ocimem_b) begin
            avm_writedata <= jdo[DATA_MSB:DATA_LSB];
            overrun       <= 1'b0;
            state         <= ST_WRITE;
            avm_write     <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            overrun       <= 1'b0;
            state         <= ST_READ;
            avm_read      <= 1'b1;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
          end
        end
        ST_READ, ST_WRITE: begin
          if (strobe_any)
            overrun <= 1'b1;
          if (!avm_waitrequest) begin
            if (state == ST_READ)
              MonDReg <= avm_readdata;
            avm_address   <= avm_address + ADDR_W'(4);
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            monitor_ready <= 1'b1;
            // A strobe dropped on the completing edge still counts as overrun.
            monitor_error <= overrun | strobe_any;
            state         <= ST_IDLE;
          end else if (expired) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_cpu_jtag_mem_sequencer.sv
// Bench for the JTAG memory sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a command-level model.
module tb_nios_system_cpu_jtag_mem_sequencer;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0, sb = 1'b0, sn = 1'b0;
  logic [31:0] rdata = '0;
  logic        wr = 1'b0;

  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios_system_cpu_jtag_mem_sequencer #(
    .TIMEOUT_CYCLES(T),
    .ADDR_W        (32)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (sa),
    .take_action_ocimem_b   (sb),
    .take_no_action_ocimem_a(sn),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_write              (avm_write),
    .avm_writedata          (avm_writedata),
    .avm_byteenable         (avm_byteenable),
    .avm_readdata           (rdata),
    .avm_waitrequest        (wr),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .busy                   (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic op, input logic [31:0] v);
    return {2'b00, op, 3'b000, v};
  endfunction

  // Command-level model: kind 0 = no command, 1 = read, 2 = write.
  int          m_kind = 0;
  int          m_waits = 0;
  bit          m_ok = 0;
  logic [31:0] m_addr, m_wdata, m_mon;
  logic        m_ready, m_err, m_over;

  task automatic m_start(input int kind);
    m_kind  = kind;
    m_waits = 0;
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_over  = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_kind = 0; m_waits = 0; m_addr = '0; m_wdata = '0; m_mon = '0;
      m_ready = 1'b1; m_err = 1'b0; m_over = 1'b0; m_ok = 1;
    end else if (m_kind == 0) begin
      if (sa) begin
        m_addr = {jdo[31:2], 2'b00};
        m_over = 1'b0;
        if (jdo[35]) m_start(1);
      end else if (sb) begin
        m_wdata = jdo[31:0];
        m_start(2);
      end else if (sn) begin
        m_start(1);
      end
    end else begin
      if (sa || sb || sn) m_over = 1'b1;
      if (!wr) begin
        if (m_kind == 1) m_mon = rdata;
        m_addr  = m_addr + 32'd4;
        m_ready = 1'b1;
        m_err   = m_over;
        m_kind  = 0;
      end else begin
        m_waits++;
        if (m_waits == T) begin
          m_ready = 1'b1;
          m_err   = 1'b1;
          m_kind  = 0;
        end
      end
    end
    #1;
    if (m_ok) begin
      chk("m_read",  {31'd0, avm_read},      {31'd0, m_kind == 1});
      chk("m_write", {31'd0, avm_write},     {31'd0, m_kind == 2});
      chk("m_busy",  {31'd0, busy},          {31'd0, m_kind != 0});
      chk("m_addr",  avm_address,            m_addr);
      chk("m_wdata", avm_writedata,          m_wdata);
      chk("m_mon",   MonDReg,                m_mon);
      chk("m_ready", {31'd0, monitor_ready}, {31'd0, m_ready});
      chk("m_err",   {31'd0, monitor_error}, {31'd0, m_err});
      chk("m_be",    {28'd0, avm_byteenable}, 32'hF);
    end
  end

  int cnt;
  logic [5:0] hi;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, monitor_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},          32'd0);
    chk("rst_addr",  avm_address,            32'd0);
    chk("rst_mon",   MonDReg,                32'd0);
    reset = 1'b0;

    // read at 0x1000, no wait states
    rdata = 32'hDEADBEEF; jdo = mk(1'b1, 32'h1000); sa = 1'b1;
    @(negedge clk); sa = 1'b0;
    chk("rd_ready_low", {31'd0, monitor_ready}, 32'd0);
    chk("rd_addr", avm_address, 32'h1000);
    @(negedge clk);
    chk("rd_mon", MonDReg, 32'hDEADBEEF);
    chk("rd_ready", {31'd0, monitor_ready}, 32'd1);
    chk("rd_next", avm_address, 32'h1004);

    // address load, then write with three wait states
    jdo = mk(1'b0, 32'h2000); sa = 1'b1;
    @(negedge clk); sa = 1'b0;
    chk("ld_busy", {31'd0, busy}, 32'd0);
    chk("ld_addr", avm_address, 32'h2000);
    jdo = mk(1'b0, 32'h12345678); sb = 1'b1; wr = 1'b1; cnt = 0;
    @(negedge clk); sb = 1'b0;
    chk("wr_addr", avm_address, 32'h2000);
    for (int k = 0; k < 10; k++) begin
      if (avm_write) cnt++;
      wr = (cnt < 4);
      @(negedge clk);
    end
    chk("wr_cycles", cnt, 32'd4);
    chk("wr_err", {31'd0, monitor_error}, 32'd0);
    chk("wr_next", avm_address, 32'h2004);
    chk("wr_data", avm_writedata, 32'h12345678);

    // waitrequest stuck: timeout after T wait cycles
    wr = 1'b1; sn = 1'b1;
    @(negedge clk); sn = 1'b0; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (avm_read) cnt++;
      @(negedge clk);
    end
    chk("to_cycles", cnt, T);
    chk("to_err", {31'd0, monitor_error}, 32'd1);
    chk("to_ready", {31'd0, monitor_ready}, 32'd1);
    chk("to_addr", avm_address, 32'h2004);
    chk("to_mon", MonDReg, 32'hDEADBEEF);
    wr = 1'b0;

    // simultaneous a+b: only the address/read runs
    rdata = 32'hCAFEF00D; jdo = mk(1'b1, 32'h3000); sa = 1'b1; sb = 1'b1;
    @(negedge clk); sa = 1'b0; sb = 1'b0;
    chk("pri_read", {31'd0, avm_read}, 32'd1);
    chk("pri_write", {31'd0, avm_write}, 32'd0);
    @(negedge clk);
    chk("pri_mon", MonDReg, 32'hCAFEF00D);
    chk("pri_wdata", avm_writedata, 32'h12345678);
    chk("pri_addr", avm_address, 32'h3004);

    // strobe while busy is dropped and flagged
    wr = 1'b1; sn = 1'b1;
    @(negedge clk); sn = 1'b0;
    @(negedge clk); sb = 1'b1; jdo = mk(1'b0, 32'h55);
    @(negedge clk); sb = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("ovr_err", {31'd0, monitor_error}, 32'd1);
    chk("ovr_wdata", avm_writedata, 32'h12345678);
    chk("ovr_addr", avm_address, 32'h3008);
    sn = 1'b1;
    @(negedge clk); sn = 1'b0;
    @(negedge clk);
    chk("ovr_clear", {31'd0, monitor_error}, 32'd0);

    // wrap at top of address space
    jdo = mk(1'b0, 32'hFFFFFFFC); sa = 1'b1;
    @(negedge clk); sa = 1'b0; sn = 1'b1;
    @(negedge clk); sn = 1'b0;
    @(negedge clk);
    chk("wrap_addr", avm_address, 32'h0);

    // reset in the middle of a stalled read
    wr = 1'b1; sn = 1'b1;
    @(negedge clk); sn = 1'b0;
    @(negedge clk);
    chk("mid_read", {31'd0, avm_read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rd0", {31'd0, avm_read}, 32'd0);
    chk("mid_ready", {31'd0, monitor_ready}, 32'd1);
    chk("mid_mon", MonDReg, 32'd0);
    chk("mid_addr", avm_address, 32'd0);
    reset = 1'b0; wr = 1'b0;

    // randomized traffic, checked by the model every cycle
    for (int k = 0; k < 1500; k++) begin
      sa = ($urandom % 8) == 0;
      sb = ($urandom % 8) == 0;
      sn = ($urandom % 8) == 0;
      hi = 6'($urandom);
      jdo = {hi, 32'($urandom)};
      rdata = $urandom;
      wr = ((k / 100) % 3 == 2) ? (($urandom % 16) != 0) : (($urandom % 3) == 0);
      reset = ($urandom % 250) == 0;
      @(negedge clk);
    end
    sa = 1'b0; sb = 1'b0; sn = 1'b0; reset = 1'b0; wr = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_system_cpu_jtag_mem_sequencer.md
NIOS_SYSTEM_CPU_JTAG_MEM_SEQUENCER -- requirements
Module: nios_system_cpu_jtag_mem_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, 255: maximum consecutive waitrequest cycles before abort (1..255).
REQ-002 SHALL have parameter ADDR_W, 32: Avalon byte-address width.
REQ-003 SHALL have clk input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have reset input 1: synchronous, active-high reset.
REQ-005 SHALL have jdo input 38: JTAG debug data word from the sysclk half.
REQ-006 SHALL have take_action_ocimem_a input 1: address-load / read-at-address strobe (1 cycle).
REQ-007 SHALL have take_action_ocimem_b input 1: write-data strobe (1 cycle).
REQ-008 SHALL have take_no_action_ocimem_a input 1: read-next strobe (1 cycle).
REQ-009 SHALL have avm_address output ADDR_W: master address, bits [1:0] always 0.
REQ-010 SHALL have avm_read output 1, avm_write output 1, avm_writedata output 32, avm_byteenable output 4 (constant 4'hF).
REQ-011 SHALL have avm_readdata input 32 and avm_waitrequest input 1.
REQ-012 SHALL have MonDReg output 32: last read data.
REQ-013 SHALL have monitor_ready output 1 (idle/complete), monitor_error output 1 (last command failed), busy output 1 (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE.
REQ-015 Strobes SHALL be accepted only in IDLE; simultaneous-strobe priority: ocimem_a > ocimem_b > no_action_ocimem_a.
REQ-016 ocimem_a with jdo[35]=0 SHALL load address <= {jdo[ADDR_W-1:2],2'b00} and stay in IDLE; monitor_ready stays 1.
REQ-017 ocimem_a with jdo[35]=1 SHALL load that address and enter READ next cycle.
REQ-018 ocimem_b SHALL latch avm_writedata <= jdo[31:0] and enter WRITE at the current address.
REQ-019 no_action_ocimem_a SHALL enter READ at the current address.
REQ-020 On any accepted READ/WRITE start: monitor_ready <= 0, monitor_error <= 0 in the same edge.
REQ-021 In READ: avm_read=1; completion when avm_waitrequest=0; MonDReg <= avm_readdata that edge.
REQ-022 In WRITE: avm_write=1; completion when avm_waitrequest=0.
REQ-023 On completion: address <= address+4 (mod 2^ADDR_W, 0xFFFFFFFC wraps to 0), monitor_ready <= 1, return to IDLE; minimum latency strobe-to-ready = 2 cycles.
REQ-024 Wait counter SHALL count cycles with waitrequest=1 in READ/WRITE, clear on entry; at count == TIMEOUT_CYCLES with waitrequest still 1: deassert read/write, monitor_error <= 1, monitor_ready <= 1, address unchanged, MonDReg unchanged, return to IDLE.
REQ-025 Strobe arriving while busy SHALL be dropped and set a sticky overrun flag; at completion monitor_error <= overrun | timeout; overrun cleared on next accepted command.
REQ-026 avm_read and avm_write SHALL never be asserted together; both SHALL be held stable with address/writedata while waitrequest=1.

Reset
REQ-027 reset SHALL force: state IDLE, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, MonDReg=0, monitor_ready=1, monitor_error=0, busy=0, counter=0, overrun=0.
REQ-028 reset mid-transaction SHALL abort immediately in the same edge; no completion, address not incremented.

Structure
REQ-029 State enum, jdo field positions (opcode bit 35, data [31:0]) and byteenable constant SHALL live in package nios_system_cpu_jtag_mem_pkg.
REQ-030 Wait counter SHALL be one sub-module nios_system_cpu_jtag_mem_timeout (clear, enable, expired).

Verification
REQ-031 ocimem_a jdo[35]=1 addr 0x1000, waitrequest=0, readdata 0xDEADBEEF -> MonDReg=0xDEADBEEF, ready=1 two cycles after strobe, address=0x1004.
REQ-032 ocimem_a jdo[35]=0 addr 0x2000 then ocimem_b data 0x12345678 with waitrequest high 3 cycles -> write held 4 cycles at 0x2000, error=0, address=0x2004.
REQ-033 waitrequest stuck high, TIMEOUT_CYCLES=8 -> read deasserted after 8 wait cycles, error=1, ready=1, address unchanged.
REQ-034 ocimem_a and ocimem_b same cycle -> only address load/read executed; strobe during busy -> dropped, error=1 at completion.
REQ-035 address 0xFFFFFFFC read-next -> address wraps to 0x00000000.
REQ-036 reset asserted in READ with waitrequest=1 -> next cycle avm_read=0, ready=1, MonDReg=0.
